// File: rtl/goldschmidt_pkg.sv
// Shared types and constant helpers for the sequenced Goldschmidt divider.
package goldschmidt_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t LOAD  = 3'd1;
  localparam state_t MUL_D = 3'd2;
  localparam state_t MUL_N = 3'd3;
  localparam state_t ROUND = 3'd4;
  localparam state_t DONE  = 3'd5;

  // Internal width: one integer bit of headroom plus guard fraction bits.
  function automatic int unsigned iw(input int unsigned width, input int unsigned guard);
    return width + guard + 1;
  endfunction

  // round(1 / (1 + (i+0.5)/2^lut_bits)) in Q2.(iw_bits-2), evaluated as an integer ratio.
  function automatic logic [63:0] ia_entry(input int unsigned i, input int unsigned lut_bits,
                                           input int unsigned iw_bits);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'd1 << (iw_bits - 2 + lut_bits + 1);
    den = (64'd1 << (lut_bits + 1)) + 64'(2 * i + 1);
    return ((num << 1) + den) / (den << 1);
  endfunction

endpackage

// File: rtl/goldschmidt_ia_rom.sv
// Initial-approximation ROM: divisor fraction MSBs -> reciprocal seed in Q2.(IW-2).
module goldschmidt_ia_rom
  import goldschmidt_pkg::*;
#(
  parameter int unsigned LUT_BITS = 4,
  parameter int unsigned IW       = 20
) (
  input  logic [LUT_BITS-1:0] addr,
  output logic [IW-1:0]       ia_c
);

  logic [IW-1:0] rom [2**LUT_BITS];

  for (genvar i = 0; i < 2**LUT_BITS; i++) begin : g_rom
    assign rom[i] = IW'(ia_entry(32'(i), LUT_BITS, IW));
  end

  assign ia_c = rom[addr];

endmodule

// File: rtl/goldschmidt_div_seq.sv
// Self-sequenced Goldschmidt divider: Q = N / D on normalised Q1.(WIDTH-1) operands,
// one shared multiplier alternating between the D and N refinement steps.
module goldschmidt_div_seq
  import goldschmidt_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned GUARD    = 3,
  parameter int unsigned ITER     = 4,
  parameter int unsigned LUT_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             err
);

  localparam int unsigned IW    = iw(WIDTH, GUARD);
  localparam int unsigned CNT_W = $clog2(ITER + 1);
  localparam logic [IW-1:0] TWO = IW'(2) << (IW - 2);

  state_t          state_q;
  state_t          state_nxt;
  logic [IW-1:0]   n_q;
  logic [IW-1:0]   d_q;
  logic [IW-1:0]   k_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IW-1:0]   ia_c;
  logic [IW-1:0]   mul_a_c;
  logic [2*IW-1:0] prod_c;
  logic [IW-1:0]   trunc_c;
  logic [IW-1:0]   two_minus_d_c;
  logic [WIDTH:0]  rnd_c;
  logic            sat_c;
  logic            accept_c;
  logic            last_pair_c;

  goldschmidt_ia_rom #(
    .LUT_BITS (LUT_BITS),
    .IW       (IW)
  ) u_ia_rom (
    .addr (d_in[WIDTH-2 -: LUT_BITS]),
    .ia_c (ia_c)
  );

  assign accept_c    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_pair_c = (cnt_q == CNT_W'(ITER));

  // Shared multiplier: D operand in MUL_D, N operand otherwise; product rescaled to Q2.(IW-2).
  assign mul_a_c       = (state_q == MUL_D) ? d_q : n_q;
  assign prod_c        = (2*IW)'(mul_a_c) * (2*IW)'(k_q);
  assign trunc_c       = IW'(prod_c >> (IW - 2));
  assign two_minus_d_c = TWO - d_q;

  // Round-half-up on the first dropped bit; carry-out or an integer part of 2 saturates.
  assign rnd_c = {1'b0, n_q[IW-2 -: WIDTH]} + (WIDTH+1)'(n_q[IW-2-WIDTH]);
  assign sat_c = n_q[IW-1] | rnd_c[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = d_q[IW-2] ? MUL_D : DONE;
      MUL_D:   state_nxt = MUL_N;
      MUL_N:   state_nxt = last_pair_c ? ROUND : MUL_D;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers; K switches from the ROM seed to 2-D after every N step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q   <= '0;
      d_q   <= '0;
      k_q   <= '0;
      cnt_q <= '0;
    end else if (accept_c) begin
      n_q   <= {1'b0, n_in, {GUARD{1'b0}}};
      d_q   <= {1'b0, d_in, {GUARD{1'b0}}};
      k_q   <= ia_c;
      cnt_q <= '0;
    end else begin
      case (state_q)
        MUL_D: d_q <= trunc_c;
        MUL_N: begin
          n_q <= trunc_c;
          k_q <= two_minus_d_c;
          if (!last_pair_c) cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready <= 1'b1;
      done  <= 1'b0;
      q     <= '0;
      err   <= 1'b0;
    end else begin
      ready <= (state_nxt == IDLE) || (state_nxt == DONE);
      done  <= (state_nxt == DONE);
      if (state_q == ROUND) begin
        q   <= sat_c ? '1 : rnd_c[WIDTH-1:0];
        err <= 1'b0;
      end else if ((state_q == LOAD) && !d_q[IW-2]) begin
        q   <= '0;
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_goldschmidt_div_seq.sv
// Directed and random checks of goldschmidt_div_seq against a real-number quotient model.
module tb_goldschmidt_div_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned ITER  = 4;
  localparam int TOL     = (ITER >= 4) ? 1 : 4;
  localparam int EXP_LAT = 2 * ITER + 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] n_in;
  logic [WIDTH-1:0] d_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] q;
  logic             err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  goldschmidt_div_seq #(
    .WIDTH    (WIDTH),
    .GUARD    (3),
    .ITER     (ITER),
    .LUT_BITS (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .n_in  (n_in),
    .d_in  (d_in),
    .ready (ready),
    .done  (done),
    .q     (q),
    .err   (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Quotient comparison with an ulp tolerance around the expected value.
  task automatic check_q(input string tag, input logic [WIDTH-1:0] qv, input int exp);
    int   diff;
    logic ok;
    diff = int'(qv) - exp;
    if (diff < 0) diff = -diff;
    ok = (diff <= TOL);
    checks++;
    assert (ok === 1'b1) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed q=0x%0h expected 0x%0h +/-%0d ulp", tag, qv, exp, TOL);
    end
  endtask

  // Exact ratio scaled to Q1.15, rounded to nearest and clipped to the largest code.
  function automatic int ref_q(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
    real r;
    r = (real'(n) / real'(d)) * 32768.0;
    if (r >= 65535.0) return 65535;
    return int'($floor(r + 0.5));
  endfunction

  // One operation: latency counts the accept cycle as 0; 0 means done never came.
  task automatic run_op(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d,
                        output logic [WIDTH-1:0] qo, output logic eo, output int lat);
    @(negedge clk);
    n_in  = n;
    d_in  = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c + 1;
        break;
      end
    end
    qo = q;
    eo = err;
  endtask

  initial begin
    logic [WIDTH-1:0] qv;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] rn;
    logic [WIDTH-1:0] rd;
    logic             ev;
    logic             stable;
    int               lat;
    int               ndone;
    int               t1;
    int               t2;

    reset = 1'b1;
    start = 1'b0;
    n_in  = '0;
    d_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_q",     32'(q),     32'd0);
    check("rst_err",   32'(err),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(16'h85E5, 16'hFDD8, qv, ev, lat);
    check("t1_lat", 32'(lat), 32'(EXP_LAT));
    check("t1_err", 32'(ev), 32'd0);
    check_q("t1_q", qv, 32'h4384);

    run_op(16'h8000, 16'h8000, qv, ev, lat);
    check("one_q", 32'(qv), 32'h8000);
    check("one_err", 32'(ev), 32'd0);

    run_op(16'hFFFF, 16'h8000, qv, ev, lat);
    check("max_q", 32'(qv), 32'hFFFF);

    run_op(16'h1234, 16'h4000, qv, ev, lat);
    check("unnorm_lat", 32'(lat), 32'd2);
    check("unnorm_err", 32'(ev), 32'd1);
    check("unnorm_q", 32'(qv), 32'd0);

    run_op(16'h1234, 16'h0000, qv, ev, lat);
    check("zero_lat", 32'(lat), 32'd2);
    check("zero_err", 32'(ev), 32'd1);
    check("zero_q", 32'(qv), 32'd0);

    // start held through the busy period and the done cycle; operands swapped mid-flight
    @(negedge clk);
    n_in  = 16'hA000;
    d_in  = 16'hC000;
    start = 1'b1;
    @(posedge clk);
    #1;
    n_in   = 16'h9000;
    d_in   = 16'hE800;
    ndone  = 0;
    t1     = 0;
    t2     = 0;
    stable = 1'b1;
    q1     = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (ndone == 1 && c == t1 + 1) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          t1 = c;
          q1 = q;
          check_q("b2b_q1", q, ref_q(16'hA000, 16'hC000));
        end else if (ndone == 2) begin
          t2 = c;
          check_q("b2b_q2", q, ref_q(16'h9000, 16'hE800));
        end
      end else if (ndone == 1 && q !== q1) begin
        stable = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(ndone), 32'd2);
    check("b2b_lat1", 32'(t1 + 1), 32'(EXP_LAT));
    check("b2b_gap", 32'(t2 - t1), 32'(EXP_LAT));
    check("b2b_hold", 32'(stable), 32'd1);

    // reset in cycle 6 of an operation clears outputs without waiting for a clock edge
    @(negedge clk);
    n_in  = 16'hC123;
    d_in  = 16'h9ABC;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_done",  32'(done),  32'd0);
    check("midrst_q",     32'(q),     32'd0);
    check("midrst_err",   32'(err),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(16'hC123, 16'h9ABC, qv, ev, lat);
    check("post_rst_lat", 32'(lat), 32'(EXP_LAT));
    check_q("post_rst_q", qv, ref_q(16'hC123, 16'h9ABC));

    for (int i = 0; i < 150; i++) begin
      rn = 16'($urandom);
      rd = 16'($urandom);
      rd[WIDTH-1] = ($urandom_range(0, 9) != 0);
      run_op(rn, rd, qv, ev, lat);
      if (rd[WIDTH-1]) begin
        check("rand_lat", 32'(lat), 32'(EXP_LAT));
        check("rand_err", 32'(ev), 32'd0);
        check_q("rand_q", qv, ref_q(rn, rd));
      end else begin
        check("rand_unnorm_lat", 32'(lat), 32'd2);
        check("rand_unnorm_err", 32'(ev), 32'd1);
        check("rand_unnorm_q", 32'(qv), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
